// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// Each 4-bit lookahead group gets its own pipeline stage. The group carry-out
// is registered and becomes the carry-in of the next stage. Operand bits that
// are not yet processed travel alongside the partial sum.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready is combinational)
//   a, b, cin, sub       operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready  result handshake
//   s, cout, ovf         sum/difference, MSB carry-out, signed overflow
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in the range 4..64");
  end

  // Lookahead carries for one 4-bit group: [0] = carry-in, [i+1] = carry out of bit i.
  function automatic logic [4:0] group_carries(input logic [3:0] p,
                                               input logic [3:0] g,
                                               input logic       c);
    logic [4:0] cy;
    cy[0] = c;
    cy[1] = g[0] | (p[0] & c);
    cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    return cy;
  endfunction

  // Stage registers: remaining operand bits, partial sum, group carry-out, valid.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  // Stage inputs (predecessor registers, or the ports for stage 0).
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  // Stage next-state values.
  logic [WIDTH-1:0] a_nx [STAGES];
  logic [WIDTH-1:0] b_nx [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic             c_nx [STAGES];
  logic             v_nx [STAGES];
  logic             ovf_nx;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;

  // Subtraction is a + ~b + 1; a borrow-in cancels the +1.
  assign b_eff = sub ? ~b : b;
  assign c0    = cin ^ sub;

  // The whole pipe moves together whenever the output slot is free or draining.
  assign adv      = !v_q[STAGES-1] | out_ready;
  assign in_ready = adv;

  // Stage input selection.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
      s_in[k] = '0;
      c_in[k] = 1'b0;
      v_in[k] = 1'b0;
    end
    a_in[0] = a;
    b_in[0] = b_eff;
    c_in[0] = c0;
    v_in[0] = in_valid & adv;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  // Per-stage group add; stage k resolves bits [4k+3:4k].
  always_comb begin
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] cy;
    p      = '0;
    g      = '0;
    cy     = '0;
    ovf_nx = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      a_nx[k] = '0;
      b_nx[k] = '0;
      s_nx[k] = '0;
      c_nx[k] = 1'b0;
      v_nx[k] = 1'b0;
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      p  = a_in[k][4*k +: 4] ^ b_in[k][4*k +: 4];
      g  = a_in[k][4*k +: 4] & b_in[k][4*k +: 4];
      cy = group_carries(p, g, c_in[k]);

      // Processed operand bits are dropped; only the upper bits travel on.
      a_nx[k]            = a_in[k];
      a_nx[k][4*k +: 4]  = 4'h0;
      b_nx[k]            = b_in[k];
      b_nx[k][4*k +: 4]  = 4'h0;

      // Lower result bits pass through untouched; this group's sum is inserted.
      s_nx[k]            = s_in[k];
      s_nx[k][4*k +: 4]  = p ^ cy[3:0];

      c_nx[k] = cy[4];
      v_nx[k] = v_in[k];

      // Signed overflow: carry into the MSB differs from carry out of it.
      if (k == STAGES - 1) begin
        ovf_nx = cy[3] ^ cy[4];
      end
    end
  end

  // Pipeline registers; invalid stages shift along with valid ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_nx[k];
        b_q[k] <= b_nx[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= c_nx[k];
        v_q[k] <= v_nx[k];
      end
      ovf_q <= ovf_nx;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder: WIDTH 4, 16 and 64 instances share one
// stimulus bus, and sel picks the active one. Results are checked against an
// arithmetic reference model kept in a scoreboard queue.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        in_valid, out_ready, cin, sub;
  logic [63:0] a_g, b_g;
  logic        in_ready_g, out_valid_g, cout_g, ovf_g;
  logic [63:0] s_g;

  logic        iv4, ir4, ov4, or4, co4, of4;
  logic [3:0]  s4;
  logic        iv16, ir16, ov16, or16, co16, of16;
  logic [15:0] s16;
  logic        iv64, ir64, ov64, or64, co64, of64;
  logic [63:0] s64;

  always #5 clk = ~clk;

  assign iv4  = in_valid & (sel == 2'd0);
  assign iv16 = in_valid & (sel == 2'd1);
  assign iv64 = in_valid & (sel == 2'd2);
  assign or4  = (sel == 2'd0) ? out_ready : 1'b1;
  assign or16 = (sel == 2'd1) ? out_ready : 1'b1;
  assign or64 = (sel == 2'd2) ? out_ready : 1'b1;

  cla_pipe_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a_g[3:0]), .b(b_g[3:0]), .cin(cin), .sub(sub),
    .out_valid(ov4), .out_ready(or4), .s(s4), .cout(co4), .ovf(of4)
  );

  cla_pipe_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a_g[15:0]), .b(b_g[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(or16), .s(s16), .cout(co16), .ovf(of16)
  );

  cla_pipe_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
    .a(a_g), .b(b_g), .cin(cin), .sub(sub),
    .out_valid(ov64), .out_ready(or64), .s(s64), .cout(co64), .ovf(of64)
  );

  always_comb begin
    case (sel)
      2'd0: begin
        in_ready_g = ir4;  out_valid_g = ov4;  s_g = 64'(s4);  cout_g = co4;  ovf_g = of4;
      end
      2'd1: begin
        in_ready_g = ir16; out_valid_g = ov16; s_g = 64'(s16); cout_g = co16; ovf_g = of16;
      end
      default: begin
        in_ready_g = ir64; out_valid_g = ov64; s_g = s64;      cout_g = co64; ovf_g = of64;
      end
    endcase
  end

  int     n_cmp = 0;
  int     n_fail = 0;
  int     n_out = 0;
  exp_t   q[$];
  logic   hold_prev = 1'b0;
  exp_t   prev;
  vec_t   vecs [8];

  function automatic int unsigned w_of(input logic [1:0] sl);
    return (sl == 2'd0) ? 4 : (sl == 2'd1) ? 16 : 64;
  endfunction

  // Reference: {cout, s} = a + (sub ? ~b : b) + (cin ^ sub) in w+1 bits.
  function automatic exp_t model(input int unsigned w, input logic [63:0] av,
                                 input logic [63:0] bv, input logic ci, input logic sb);
    logic [64:0] mask, aa, bb, full;
    exp_t r;
    mask   = (65'd1 << w) - 65'd1;
    aa     = {1'b0, av} & mask;
    bb     = (sb ? ~{1'b0, bv} : {1'b0, bv}) & mask;
    full   = aa + bb + 65'(ci ^ sb);
    r.s    = 64'(full & mask);
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return r;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive after the edge, observe at the falling edge.
  task automatic step(input logic iv, input logic [63:0] av, input logic [63:0] bv,
                      input logic ci, input logic sb, input logic ordy, output logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = iv; a_g = av; b_g = bv; cin = ci; sub = sb; out_ready = ordy;
    @(negedge clk);
    if (hold_prev) begin
      chk("hold_valid", 64'(out_valid_g), 64'd1);
      chk("hold_s", s_g, prev.s);
      chk("hold_cout", 64'(cout_g), 64'(prev.cout));
      chk("hold_ovf", 64'(ovf_g), 64'(prev.ovf));
    end
    if (out_valid_g && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid_g), 64'd0);
      end else begin
        e = q.pop_front();
        chk("res_s", s_g, e.s);
        chk("res_cout", 64'(cout_g), 64'(e.cout));
        chk("res_ovf", 64'(ovf_g), 64'(e.ovf));
      end
    end
    acc = in_valid && in_ready_g;
    if (acc) q.push_back(model(w_of(sel), av, bv, ci, sb));
    hold_prev = out_valid_g && !out_ready;
    prev.s    = s_g;
    prev.cout = cout_g;
    prev.ovf  = ovf_g;
  endtask

  task automatic drain();
    logic acc;
    int   c = 0;
    while (q.size() != 0 && c < 200) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      c++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic run_random(input logic [1:0] sl, input int n);
    logic acc;
    int   sent = 0;
    int   cyc = 0;
    sel = sl;
    while (sent < n && cyc < n * 4) begin
      step(($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), acc);
      if (acc) sent++;
      cyc++;
    end
    chk($sformatf("rand_w%0d_sent", w_of(sl)), 64'(sent), 64'(n));
    drain();
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   lat, cyc, sent, base;
    logic ordy;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};

    rst = 1'b1; sel = 2'd1; in_valid = 1'b0; out_ready = 1'b1;
    a_g = '0; b_g = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #1;
      chk($sformatf("rst_valid_w%0d", w_of(sel)), 64'(out_valid_g), 64'd0);
      chk($sformatf("rst_s_w%0d", w_of(sel)), s_g, 64'd0);
      chk($sformatf("rst_cout_w%0d", w_of(sel)), 64'(cout_g), 64'd0);
      chk($sformatf("rst_ovf_w%0d", w_of(sel)), 64'(ovf_g), 64'd0);
    end
    sel = 2'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready_g), 64'd1);
    out_ready = 1'b1;

    // Directed vectors, one at a time, with latency check.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin, vecs[i].sub, 1'b1, acc);
      chk($sformatf("vec%0d_accept", i), 64'(acc), 64'd1);
      lat = 0;
      do begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        lat++;
      end while (!out_valid_g && lat < 20);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_s", i), s_g, 64'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 64'(cout_g), 64'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 64'(ovf_g), 64'(vecs[i].ovf));
    end
    drain();

    // WIDTH=4: single stage, latency 1.
    sel = 2'd0;
    step(1'b1, 64'hF, 64'h1, 1'b0, 1'b0, 1'b1, acc);
    lat = 0;
    do begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      lat++;
    end while (!out_valid_g && lat < 20);
    chk("w4_latency", 64'(lat), 64'd1);
    chk("w4_s", s_g, 64'h0);
    chk("w4_cout", 64'(cout_g), 64'd1);
    chk("w4_ovf", 64'(ovf_g), 64'd0);
    drain();

    // Full rate: 8 back-to-back sets leave on 8 consecutive cycles.
    sel = 2'd1;
    base = n_out; cyc = 0; sent = 0;
    while ((n_out - base) < 8 && cyc < 40) begin
      step(sent < 8, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b1, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("thru_cycles", 64'(cyc), 64'd12);
    drain();

    // Backpressure: out_ready low in cycles 5..9.
    base = n_out; cyc = 0; sent = 0;
    while ((n_out - base) < 8 && cyc < 60) begin
      ordy = !(cyc >= 5 && cyc <= 9);
      step(sent < 8, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), ordy, acc);
      if (cyc >= 5 && cyc <= 9) begin
        chk($sformatf("bp_in_ready_c%0d", cyc), 64'(in_ready_g), 64'd0);
        chk($sformatf("bp_out_valid_c%0d", cyc), 64'(out_valid_g), 64'd1);
      end
      if (acc) sent++;
      cyc++;
    end
    chk("bp_results", 64'(n_out - base), 64'd8);
    drain();

    // Reset with three sets in flight: none may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b1, acc);
      chk($sformatf("mid_rst_accept%0d", i), 64'(acc), 64'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid_g), 64'd0);
    chk("mid_rst_s", s_g, 64'd0);
    chk("mid_rst_cout", 64'(cout_g), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready_g), 64'd1);
    repeat (8) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("mid_rst_no_stale", 64'(n_out - base - 8), 64'd0);
    step(1'b1, 64'h1234, 64'h4321, 1'b0, 1'b0, 1'b1, acc);
    drain();

    // Random regression at every width.
    run_random(2'd0, 10000);
    run_random(2'd1, 10000);
    run_random(2'd2, 10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
